lsq_part_reconfig_ctrl: RTL
===========================

LSQ_PART_RECONFIG_CTRL -- requirements
Module: lsq_part_reconfig_ctrl

Interface
REQ-001 Parameter DEPTH, default `LSQ_DEPTH; total load-queue entries across all partitions.
REQ-002 Parameter INDEX, default `SIZE_LSQ_LOG; entry address width.
REQ-003 Parameter WIDTH, default `SIZE_DATA; RAM data width.
REQ-004 Parameter NUM_PARTS, default `STRUCT_PARTS_LSQ; partition count (power of two).
REQ-005 Parameter SETTLE_CYCLES, default 4; power-up settle wait, >=1.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 reconfigReq_i  input  1  single-cycle request to apply partActiveReq_i.
REQ-009 partActiveReq_i  input  NUM_PARTS  requested active-partition mask.
REQ-010 lsqEmpty_i  input  1  high when no load/store entries are allocated.
REQ-011 partActive_o  output  NUM_PARTS  registered mask; drives the RAM lsqPartitionActive_i.
REQ-012 dispatchStall_o  output  1  blocks LSQ allocation during reconfiguration.
REQ-013 scrubWe_o / scrubAddr_o / scrubData_o  output  1/INDEX/WIDTH  scrub write port into the RAM write port 0.
REQ-014 ramReady_o  output  1  high only in IDLE.
REQ-015 reconfigDone_o  output  1  one-cycle completion pulse.

Function
REQ-016 FSM states: IDLE, DRAIN, POWER, SCRUB, DONE; all outputs registered or decoded from state.
REQ-017 Effective mask = partActiveReq_i with bit 0 forced to 1; partition 0 is never gated.
REQ-018 IDLE: on reconfigReq_i with effective mask == partActive_o -> DONE with no other effect.
REQ-019 IDLE: on reconfigReq_i with a different effective mask -> latch mask into newMask and the set bits of newMask & ~partActive_o into upMask -> DRAIN.
REQ-020 reconfigReq_i outside IDLE is ignored; it is not queued.
REQ-021 DRAIN: dispatchStall_o=1 and ramReady_o=0; stay until lsqEmpty_i=1.
REQ-022 DRAIN with lsqEmpty_i=1: partActive_o <= newMask (visible the next cycle); settle counter <= 0 -> POWER.
REQ-023 POWER: increment the counter each cycle; after exactly SETTLE_CYCLES cycles in POWER -> SCRUB if upMask != 0 and scrubbing is compiled in, else -> DONE.
REQ-024 SCRUB: one write per cycle with scrubWe_o=1, scrubData_o=0, and scrubAddr_o={part, idx}.
REQ-025 SCRUB order: ascending idx 0..DEPTH/NUM_PARTS-1 within each part; parts taken ascending, only parts whose upMask bit is set; partitions not being powered up are never written.
REQ-026 SCRUB -> DONE in the cycle after the last write; total writes = popcount(upMask)*DEPTH/NUM_PARTS.
REQ-027 DONE: reconfigDone_o=1 for exactly one cycle -> IDLE.
REQ-028 dispatchStall_o=1 in all states except IDLE.
REQ-029 Latency with lsqEmpty_i already high: request at cycle 0, DRAIN in cycle 1, POWER in cycles 2..1+SETTLE_CYCLES, SCRUB from 2+SETTLE_CYCLES, DONE after the scrub, ramReady_o high in the following cycle.
REQ-030 A partition power-down only (upMask=0) skips SCRUB entirely.
REQ-031 scrubWe_o=0 in every state other than SCRUB.

Reset
REQ-032 Reset sets: state=IDLE, partActive_o=all ones, newMask=all ones, upMask=0, counters=0, scrubWe_o=0, scrubAddr_o=0, reconfigDone_o=0, ramReady_o=1, dispatchStall_o=0.
REQ-033 Reset asserted mid-operation aborts immediately to the reset values; the partially applied mask is discarded.

Configuration
REQ-034 Macro LSQ_PART_SCRUB_EN defined: SCRUB state and scrub port are active as specified above.
REQ-035 Macro LSQ_PART_SCRUB_EN undefined: POWER always goes to DONE; scrubWe_o is tied 0 and scrubAddr_o/scrubData_o are tied 0.

Verification (NUM_PARTS=4, DEPTH=32, SETTLE_CYCLES=4, scrub enabled)
REQ-036 Reset, then a request for 4'b1111 -> DONE pulse at cycle 1, partActive_o stays 4'b1111, no scrub writes.
REQ-037 From 4'b1111, request 4'b0011 with lsqEmpty_i=1 -> partActive_o=4'b0011 at cycle 3, reconfigDone_o at cycle 6, zero scrub writes.
REQ-038 From 4'b0011, request 4'b1011 with lsqEmpty_i low for 5 cycles -> DRAIN lasts 6 cycles, then exactly 8 scrub writes to addr 24..31 with data 0.
REQ-039 Request 4'b0000 -> effective mask 4'b0001; partActive_o=4'b0001.
REQ-040 Second reconfigReq_i during POWER -> ignored; final mask equals the first request.
REQ-041 Reset asserted in SCRUB at the 3rd write -> next edge shows IDLE, partActive_o=4'b1111, scrubWe_o=0, ramReady_o=1.

Source files
------------

// File: rtl/lsq_part_reconfig_ctrl_if.sv
// lsq_part_reconfig_ctrl_if: request/status and scrub-port bundle of the LSQ partition controller.
// Revision 1.0
`default_nettype none

`ifndef SIZE_LSQ_LOG
`define SIZE_LSQ_LOG 5
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef STRUCT_PARTS_LSQ
`define STRUCT_PARTS_LSQ 4
`endif

interface lsq_part_reconfig_ctrl_if #(
    parameter int INDEX     = `SIZE_LSQ_LOG,
    parameter int WIDTH     = `SIZE_DATA,
    parameter int NUM_PARTS = `STRUCT_PARTS_LSQ
);
    logic                 reconfigReq_i;
    logic [NUM_PARTS-1:0] partActiveReq_i;
    logic                 lsqEmpty_i;
    logic [NUM_PARTS-1:0] partActive_o;
    logic                 dispatchStall_o;
    logic                 scrubWe_o;
    logic [INDEX-1:0]     scrubAddr_o;
    logic [WIDTH-1:0]     scrubData_o;
    logic                 ramReady_o;
    logic                 reconfigDone_o;

    modport master (
        output reconfigReq_i, partActiveReq_i, lsqEmpty_i,
        input  partActive_o, dispatchStall_o, scrubWe_o, scrubAddr_o, scrubData_o,
               ramReady_o, reconfigDone_o
    );

    modport slave (
        input  reconfigReq_i, partActiveReq_i, lsqEmpty_i,
        output partActive_o, dispatchStall_o, scrubWe_o, scrubAddr_o, scrubData_o,
               ramReady_o, reconfigDone_o
    );
endinterface

`default_nettype wire

// File: rtl/lsq_part_reconfig_ctrl.sv
// lsq_part_reconfig_ctrl: drains the LSQ, switches the partition power mask and zero-scrubs newly
// powered partitions. Scrubbing is built only when LSQ_PART_SCRUB_EN is defined. Revision 1.0
`default_nettype none

`ifndef LSQ_DEPTH
`define LSQ_DEPTH 32
`endif
`ifndef SIZE_LSQ_LOG
`define SIZE_LSQ_LOG 5
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef STRUCT_PARTS_LSQ
`define STRUCT_PARTS_LSQ 4
`endif

module lsq_part_reconfig_ctrl #(
    parameter int DEPTH         = `LSQ_DEPTH,
    parameter int INDEX         = `SIZE_LSQ_LOG,
    parameter int WIDTH         = `SIZE_DATA,
    parameter int NUM_PARTS     = `STRUCT_PARTS_LSQ,
    parameter int SETTLE_CYCLES = 4
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    lsq_part_reconfig_ctrl_if.slave     bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRAIN = 3'd1;
    localparam logic [2:0] S_POWER = 3'd2;
    localparam logic [2:0] S_SCRUB = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    logic [2:0]           state;
    logic [NUM_PARTS-1:0] part_active;
    logic [NUM_PARTS-1:0] new_mask;
    logic [CW-1:0]        settle_cnt;
    logic [NUM_PARTS-1:0] eff_mask;

    // Partition 0 holds the minimum queue and is never gated.
    assign eff_mask = bus.partActiveReq_i | NUM_PARTS'(1);

`ifdef LSQ_PART_SCRUB_EN
    localparam int PW = $clog2(NUM_PARTS);
    localparam int IW = INDEX - PW;
    localparam logic [IW-1:0] PART_LAST = IW'(DEPTH / NUM_PARTS - 1);

    logic [NUM_PARTS-1:0] up_mask;
    logic [NUM_PARTS-1:0] scrub_left;
    logic [NUM_PARTS-1:0] scrub_left_next;
    logic [PW-1:0]        scrub_part;
    logic [IW-1:0]        scrub_idx;

    function automatic logic [PW-1:0] lowest_set(input logic [NUM_PARTS-1:0] m);
        lowest_set = '0;
        for (int i = NUM_PARTS - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = PW'(i);
        end
    endfunction

    assign scrub_left_next = scrub_left & ~(NUM_PARTS'(1) << scrub_part);
    assign bus.scrubWe_o   = (state == S_SCRUB);
    assign bus.scrubAddr_o = {scrub_part, scrub_idx};
    assign bus.scrubData_o = '0;
`else
    assign bus.scrubWe_o   = 1'b0;
    assign bus.scrubAddr_o = '0;
    assign bus.scrubData_o = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            part_active <= '1;
            new_mask    <= '1;
            settle_cnt  <= '0;
`ifdef LSQ_PART_SCRUB_EN
            up_mask     <= '0;
            scrub_left  <= '0;
            scrub_part  <= '0;
            scrub_idx   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.reconfigReq_i) begin
                        if (eff_mask == part_active) begin
                            state <= S_DONE;
                        end else begin
                            new_mask <= eff_mask;
`ifdef LSQ_PART_SCRUB_EN
                            up_mask  <= eff_mask & ~part_active;
`endif
                            state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.lsqEmpty_i) begin
                        part_active <= new_mask;
                        settle_cnt  <= '0;
                        state       <= S_POWER;
                    end
                end
                S_POWER: begin
                    settle_cnt <= settle_cnt + CW'(1);
                    if (settle_cnt == SETTLE_LAST) begin
`ifdef LSQ_PART_SCRUB_EN
                        if (up_mask != '0) begin
                            scrub_left <= up_mask;
                            scrub_part <= lowest_set(up_mask);
                            scrub_idx  <= '0;
                            state      <= S_SCRUB;
                        end else begin
                            state <= S_DONE;
                        end
`else
                        state <= S_DONE;
`endif
                    end
                end
`ifdef LSQ_PART_SCRUB_EN
                S_SCRUB: begin
                    // Jump straight to the next powered-up partition so writes stay back to back.
                    if (scrub_idx == PART_LAST) begin
                        scrub_left <= scrub_left_next;
                        scrub_idx  <= '0;
                        if (scrub_left_next == '0) begin
                            state <= S_DONE;
                        end else begin
                            scrub_part <= lowest_set(scrub_left_next);
                        end
                    end else begin
                        scrub_idx <= scrub_idx + IW'(1);
                    end
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.partActive_o    = part_active;
    assign bus.ramReady_o      = (state == S_IDLE);
    assign bus.dispatchStall_o = (state != S_IDLE);
    assign bus.reconfigDone_o  = (state == S_DONE);

endmodule

`default_nettype wire
